// File: rtl/lab_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab_pkg
// Description : Shared constants for the lab input conditioner.
//               c_CNT_W          - width of each key's stable counter
//               c_DB_CNT_DEFAULT - default debounce length (1 ms at 50 MHz)
//               eff_db_cnt()     - debounce length actually used; 0 means 1
// Revision    : 1.0 - initial release
// ============================================================================
package lab_pkg;

    localparam int unsigned c_CNT_W = 16;
    localparam logic [c_CNT_W-1:0] c_DB_CNT_DEFAULT = 16'd50000;
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = {{(c_CNT_W-1){1'b0}}, 1'b1};

    // A zero-length debounce would never see a "differing" cycle complete,
    // so it is promoted to a single-cycle debounce.
    function automatic logic [c_CNT_W-1:0] eff_db_cnt(input logic [c_CNT_W-1:0] db_cnt);
        return (db_cnt == '0) ? c_CNT_ONE : db_cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_key.sv
`default_nettype none
// ============================================================================
// Module      : debounce_key
// Description : Conditions one active-low, bouncy, asynchronous key.
//               Two-flop synchronizer, stable counter, debounced level and a
//               one-cycle press pulse on the debounced 1->0 transition.
// Ports       : clk       - system clock
//               rst_n     - asynchronous active-low reset
//               i_key_n   - raw key (0 = pressed)
//               o_level_n - debounced level (0 = pressed)
//               o_press_p - one-cycle pulse, same cycle o_level_n falls
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_key
    import lab_pkg::*;
#(
    parameter logic [c_CNT_W-1:0] DB_CNT = c_DB_CNT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_level_n,
    output logic o_press_p
);

    localparam logic [c_CNT_W-1:0] c_EFF_CNT = eff_db_cnt(DB_CNT);
    // The counter holds the number of differing cycles already seen, so the
    // DB_CNT-th differing cycle is the one that finds c_EFF_CNT-1 stored.
    localparam logic [c_CNT_W-1:0] c_LOAD_AT = c_EFF_CNT - c_CNT_ONE;

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_pulse;
    logic [c_CNT_W-1:0] r_cnt;

    logic w_differ;
    logic w_load;

    assign w_differ = (r_sync2 != r_level);
    assign w_load   = w_differ && (r_cnt >= c_LOAD_AT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_pulse <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            // A load only happens when the level differs, so loading a 0
            // means the level is going 1->0: that is a press.
            r_pulse <= w_load && !r_sync2;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_load) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else if (r_cnt < c_EFF_CNT) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_level_n = r_level;
    assign o_press_p = r_pulse;

endmodule
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : input_conditioner
// Description : Front-panel input conditioning for the lab processor.
//               Synchronizes the data/function/routing switches and debounces
//               the LoadA, LoadB and Execute keys.
// Ports       : Clk, Reset (async, active-low)
//               LoadA_n, LoadB_n, Execute_n - raw keys, active-low
//               Din_raw[7:0], F_raw[2:0], R_raw[1:0] - raw switches
//               Din, F, R - switches delayed through two flops
//               LoadA, LoadB, Execute - debounced keys, active-low
//               LoadA_p, LoadB_p, Execute_p - one-cycle press pulses
// Revision    : 1.0 - initial release
// ============================================================================
module input_conditioner
    import lab_pkg::*;
#(
    parameter logic [c_CNT_W-1:0] DB_CNT = c_DB_CNT_DEFAULT
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       LoadA_n,
    input  logic       LoadB_n,
    input  logic       Execute_n,
    input  logic [7:0] Din_raw,
    input  logic [2:0] F_raw,
    input  logic [1:0] R_raw,
    output logic [7:0] Din,
    output logic [2:0] F,
    output logic [1:0] R,
    output logic       LoadA,
    output logic       LoadB,
    output logic       Execute,
    output logic       LoadA_p,
    output logic       LoadB_p,
    output logic       Execute_p
);

    // Switch bundle: {Din, F, R}
    logic [12:0] r_data_s1;
    logic [12:0] r_data_s2;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_data_s1 <= '0;
            r_data_s2 <= '0;
        end else begin
            r_data_s1 <= {Din_raw, F_raw, R_raw};
            r_data_s2 <= r_data_s1;
        end
    end

    assign {Din, F, R} = r_data_s2;

    debounce_key #(.DB_CNT(DB_CNT)) u_key_load_a (
        .clk       (Clk),
        .rst_n     (Reset),
        .i_key_n   (LoadA_n),
        .o_level_n (LoadA),
        .o_press_p (LoadA_p)
    );

    debounce_key #(.DB_CNT(DB_CNT)) u_key_load_b (
        .clk       (Clk),
        .rst_n     (Reset),
        .i_key_n   (LoadB_n),
        .o_level_n (LoadB),
        .o_press_p (LoadB_p)
    );

    debounce_key #(.DB_CNT(DB_CNT)) u_key_execute (
        .clk       (Clk),
        .rst_n     (Reset),
        .i_key_n   (Execute_n),
        .o_level_n (Execute),
        .o_press_p (Execute_p)
    );

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_conditioner
// Description : Self-checking bench for input_conditioner. Two instances run
//               from the same stimulus: DB_CNT=4 and DB_CNT=0 (behaves as 1).
//               Reference: a key's debounced level flips when the last N
//               synchronized samples all differ from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       LoadA_n, LoadB_n, Execute_n;
    logic [7:0] Din_raw;
    logic [2:0] F_raw;
    logic [1:0] R_raw;

    logic [7:0] Din,  Din0;
    logic [2:0] F,    F0;
    logic [1:0] R,    R0;
    logic       LoadA, LoadB, Execute, LoadA_p, LoadB_p, Execute_p;
    logic       LoadA0, LoadB0, Execute0, LoadA0_p, LoadB0_p, Execute0_p;

    input_conditioner #(.DB_CNT(16'd4)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .LoadA_n(LoadA_n), .LoadB_n(LoadB_n), .Execute_n(Execute_n),
        .Din_raw(Din_raw), .F_raw(F_raw), .R_raw(R_raw),
        .Din(Din), .F(F), .R(R),
        .LoadA(LoadA), .LoadB(LoadB), .Execute(Execute),
        .LoadA_p(LoadA_p), .LoadB_p(LoadB_p), .Execute_p(Execute_p)
    );

    input_conditioner #(.DB_CNT(16'd0)) u_dut0 (
        .Clk(Clk), .Reset(Reset),
        .LoadA_n(LoadA_n), .LoadB_n(LoadB_n), .Execute_n(Execute_n),
        .Din_raw(Din_raw), .F_raw(F_raw), .R_raw(R_raw),
        .Din(Din0), .F(F0), .R(R0),
        .LoadA(LoadA0), .LoadB(LoadB0), .Execute(Execute0),
        .LoadA_p(LoadA0_p), .LoadB_p(LoadB0_p), .Execute_p(Execute0_p)
    );

    always #5 Clk = ~Clk;

    int n_vec = 0;
    int n_bad = 0;

    // Per-edge samples as seen by the synchronizer inputs: {Execute,LoadB,LoadA}
    // and {Din,F,R}. During reset the flops hold their reset values, which is
    // what gets recorded.
    logic [2:0]  kq[$];
    logic [12:0] dq[$];
    logic [2:0]  m_lvl [2];
    logic [2:0]  m_pls [2];

    function automatic int win(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        kq.delete();
        dq.delete();
        for (int i = 0; i < 8; i++) begin
            kq.push_back(3'b111);
            dq.push_back(13'd0);
        end
        m_lvl[0] = 3'b111; m_lvl[1] = 3'b111;
        m_pls[0] = 3'b000; m_pls[1] = 3'b000;
    endtask

    task automatic step();
        logic [12:0] d;
        logic [2:0]  s;
        logic        all_diff;
        @(posedge Clk);
        if (!Reset) begin
            kq.push_back(3'b111);
            dq.push_back(13'd0);
        end else begin
            kq.push_back({Execute_n, LoadB_n, LoadA_n});
            dq.push_back({Din_raw, F_raw, R_raw});
        end
        while (kq.size() > 16) void'(kq.pop_front());
        while (dq.size() > 16) void'(dq.pop_front());
        // Synchronized value seen in the cycle before this edge is the sample
        // taken two edges ago, i.e. index size-3.
        for (int i = 0; i < 2; i++) begin
            m_pls[i] = 3'b000;
            for (int k = 0; k < 3; k++) begin
                all_diff = 1'b1;
                for (int j = 0; j < win(i); j++) begin
                    s = kq[kq.size() - 3 - j];
                    if (s[k] == m_lvl[i][k]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    m_lvl[i][k] = ~m_lvl[i][k];
                    m_pls[i][k] = ~m_lvl[i][k];
                end
            end
        end
        #1;
        d = dq[dq.size() - 2];
        check("data",  16'({Din, F, R}), 16'(d));
        check("data0", 16'({Din0, F0, R0}), 16'(d));
        check("lvl",   16'({Execute, LoadB, LoadA}), 16'(m_lvl[0]));
        check("pls",   16'({Execute_p, LoadB_p, LoadA_p}), 16'(m_pls[0]));
        check("lvl0",  16'({Execute0, LoadB0, LoadA0}), 16'(m_lvl[1]));
        check("pls0",  16'({Execute0_p, LoadB0_p, LoadA0_p}), 16'(m_pls[1]));
    endtask

    task automatic check_reset_state();
        check("rst_lvl",  16'({Execute, LoadB, LoadA}), 16'h0007);
        check("rst_pls",  16'({Execute_p, LoadB_p, LoadA_p}), 16'h0000);
        check("rst_data", 16'({Din, F, R}), 16'h0000);
        check("rst_lvl0", 16'({Execute0, LoadB0, LoadA0}), 16'h0007);
        check("rst_pls0", 16'({Execute0_p, LoadB0_p, LoadA0_p}), 16'h0000);
    endtask

    // Asserts reset mid-cycle, holds it for some edges, releases mid-cycle.
    task automatic apply_reset(input int cycles);
        Reset = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        repeat (cycles) step();
        Reset = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pc;
        int pe;
        int hold [3];
        logic [2:0] kv;

        Reset = 1'b1;
        LoadA_n = 1'b0; LoadB_n = 1'b0; Execute_n = 1'b0;
        Din_raw = 8'h00; F_raw = 3'b000; R_raw = 2'b00;
        #1;
        // Keys held low while in reset: everything reads released/zero.
        apply_reset(3);
        LoadA_n = 1'b1; LoadB_n = 1'b1; Execute_n = 1'b1;
        Reset = 1'b1;
        repeat (4) step();

        // Switch latency: two edges exactly.
        Din_raw = 8'h33; F_raw = 3'b010; R_raw = 2'b10;
        step();
        check("din_lat1", 16'({Din, F, R}), 16'h0000);
        step();
        check("din_lat2", 16'({Din, F, R}), 16'({8'h33, 3'b010, 2'b10}));
        repeat (2) step();

        // Clean press then release of Execute.
        Execute_n = 1'b0;
        pc = 0; pe = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (Execute_p) begin pc++; pe = c; end
            if (c == 5) check("ex_lvl_e5", 16'(Execute), 16'h0001);
            if (c == 6) check("ex_lvl_e6", 16'(Execute), 16'h0000);
        end
        check("ex_press_cnt", 16'(pc), 16'h0001);
        check("ex_press_edge", 16'(pe), 16'h0006);
        Execute_n = 1'b1;
        pc = 0;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (Execute_p) pc++;
            if (c == 5) check("ex_rel_e5", 16'(Execute), 16'h0000);
            if (c == 6) check("ex_rel_e6", 16'(Execute), 16'h0001);
        end
        check("ex_rel_pulses", 16'(pc), 16'h0000);

        // Short glitch on LoadA is rejected.
        pc = 0; pe = 0;
        LoadA_n = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (c == 3) LoadA_n = 1'b1;
            step();
            if (LoadA_p) pc++;
            if (!LoadA) pe++;
        end
        check("a_glitch_pulses", 16'(pc), 16'h0000);
        check("a_glitch_level", 16'(pe), 16'h0000);

        // LoadB bounces every 2 cycles, then settles low.
        pc = 0; pe = -1;
        for (int c = 0; c < 20; c++) begin
            LoadB_n = (c >= 10) ? 1'b0 : (((c / 2) % 2) != 0);
            step();
            if (LoadB_p) begin pc++; pe = c - 7; end
        end
        check("b_bounce_cnt", 16'(pc), 16'h0001);
        check("b_bounce_edge", 16'(pe), 16'h0006);
        LoadB_n = 1'b1;
        repeat (8) step();

        // Reset in the middle of an Execute count.
        Execute_n = 1'b0;
        repeat (3) step();
        apply_reset(2);
        pc = 0; pe = -1;
        for (int c = 1; c <= 10; c++) begin
            step();
            if (Execute_p) begin pc++; pe = c; end
        end
        check("rst_ex_cnt", 16'(pc), 16'h0001);
        check("rst_ex_edge", 16'(pe), 16'h0006);
        Execute_n = 1'b1;
        repeat (8) step();

        // Random bouncy keys, random switches, occasional reset.
        for (int k = 0; k < 3; k++) hold[k] = 0;
        kv = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    kv[k] = 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 8);
                end
                hold[k]--;
            end
            {Execute_n, LoadB_n, LoadA_n} = kv;
            if ($urandom_range(0, 3) == 0) begin
                Din_raw = 8'($urandom);
                F_raw   = 3'($urandom);
                R_raw   = 2'($urandom);
            end
            if ($urandom_range(0, 599) == 0) apply_reset($urandom_range(1, 3));
            else step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
